// File: rtl/masked_subbytes_ctrl_if.sv
// rtl/masked_subbytes_ctrl_if.sv - handshake/data bundle between masked SubBytes controller and its environment (SUBBYTES_CTRL_STALLCNT_EN adds StallCntxDO)
interface masked_subbytes_ctrl_if #(
    parameter int SHARES = 2,
    parameter int NBYTES = 16
);
    logic                         StartxSI;
    logic [8*SHARES*NBYTES-1:0]   StatexDI;
    logic                         RandValidxSI;
    logic                         RandAckxSO;
    logic [8*SHARES-1:0]          SboxXxDO;
    logic [8*SHARES-1:0]          SboxQxDI;
    logic [8*SHARES*NBYTES-1:0]   StatexDO;
    logic                         BusyxSO;
    logic                         DonexSO;
`ifdef SUBBYTES_CTRL_STALLCNT_EN
    logic [15:0]                  StallCntxDO;

    modport slave (
        input  StartxSI, StatexDI, RandValidxSI, SboxQxDI,
        output RandAckxSO, SboxXxDO, StatexDO, BusyxSO, DonexSO, StallCntxDO
    );

    modport master (
        output StartxSI, StatexDI, RandValidxSI, SboxQxDI,
        input  RandAckxSO, SboxXxDO, StatexDO, BusyxSO, DonexSO, StallCntxDO
    );
`else
    modport slave (
        input  StartxSI, StatexDI, RandValidxSI, SboxQxDI,
        output RandAckxSO, SboxXxDO, StatexDO, BusyxSO, DonexSO
    );

    modport master (
        output StartxSI, StatexDI, RandValidxSI, SboxQxDI,
        input  RandAckxSO, SboxXxDO, StatexDO, BusyxSO, DonexSO
    );
`endif
endinterface

// File: rtl/masked_subbytes_ctrl.sv
// rtl/masked_subbytes_ctrl.sv - sequences a masked SubBytes layer through one shared pipelined S-box (optional SUBBYTES_CTRL_STALLCNT_EN stall counter)
module masked_subbytes_ctrl #(
    parameter int SHARES  = 2,
    parameter int NBYTES  = 16,
    parameter int LATENCY = 5
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    masked_subbytes_ctrl_if.slave bus
);
    localparam int BW = 8 * SHARES;
    localparam int SW = BW * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [SW-1:0]      latch_q;
    logic [SW-1:0]      result_q;
    logic [IW-1:0]      issue_idx_q;
    logic [CW-1:0]      cap_cnt_q;
    logic [LATENCY-1:0] vpipe_q;
    logic               busy_q;
    logic               done_q;

    logic               accept_start;
    logic               issue;
    logic               capture;
    logic               last_issue;
    logic               last_capture;
    logic [IW-1:0]      cap_idx;

    // A start is honoured only when no run is in progress.
    assign accept_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.StartxSI;

    // A byte leaves for the S-box only when a fresh mask bundle is on offer.
    assign issue        = (state_q == S_ISSUE) && bus.RandValidxSI;
    assign capture      = vpipe_q[LATENCY-1];
    assign last_issue   = (issue_idx_q == IW'(NBYTES - 1));
    assign last_capture = (cap_cnt_q == CW'(NBYTES - 1));
    assign cap_idx      = cap_cnt_q[IW-1:0];

    // Bubbles drive zeros so no stale share ever re-enters the S-box.
    assign bus.RandAckxSO = issue;
    assign bus.SboxXxDO   = issue ? latch_q[int'(issue_idx_q)*BW +: BW] : '0;
    assign bus.StatexDO   = result_q;
    assign bus.BusyxSO    = busy_q;
    assign bus.DonexSO    = done_q;

    // Run sequencing, in-flight tracking and result collection.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q     <= S_IDLE;
            latch_q     <= '0;
            result_q    <= '0;
            issue_idx_q <= '0;
            cap_cnt_q   <= '0;
            vpipe_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            vpipe_q <= LATENCY'({vpipe_q, issue});
            if (capture) begin
                result_q[int'(cap_idx)*BW +: BW] <= bus.SboxQxDI;
                cap_cnt_q                        <= cap_cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_start) begin
                        latch_q     <= bus.StatexDI;
                        issue_idx_q <= '0;
                        cap_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        if (last_issue) begin
                            state_q <= S_DRAIN;
                        end else begin
                            issue_idx_q <= issue_idx_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last capture and the done pulse land on the same edge.
                    if (capture && last_capture) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SUBBYTES_CTRL_STALLCNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of randomness-starved issue cycles in the current run.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            stall_cnt_q <= '0;
        end else if (accept_start) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_ISSUE) && !bus.RandValidxSI && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.StallCntxDO = stall_cnt_q;
`endif

endmodule
